// File: rtl/sccb_target_if.sv
// sccb_target_if: bus and register-port bundle for sccb_target.
//   SIOC_in / SIOD_in : bus line levels as seen by the target (asynchronous)
//   SIOD_oe           : 1 = target pulls SIOD low, 0 = released
//   busy              : transaction in progress (START seen, no STOP yet)
//   wr_valid          : one-cycle register-write strobe
//   wr_addr / wr_data : sub-address / data of the last completed write
//   rd_addr           : last received sub-address
//   rd_data           : register value for rd_addr (read-capable builds only)
// Modports: master = bus initiator / register-file side, slave = sccb_target.
interface sccb_target_if;
  logic       SIOC_in;
  logic       SIOD_in;
  logic       SIOD_oe;
  logic       busy;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output SIOC_in, SIOD_in, rd_data,
    input  SIOD_oe, busy, wr_valid, wr_addr, wr_data, rd_addr
  );

  modport slave (
    input  SIOC_in, SIOD_in, rd_data,
    output SIOD_oe, busy, wr_valid, wr_addr, wr_data, rd_addr
  );
endinterface

// File: rtl/sccb_target.sv
// sccb_target: SCCB write target (camera-side responder).
//   Passively samples SIOC/SIOD, detects START/STOP, ACKs 3-phase writes to
//   DEV_ID by pulling SIOD low, and emits one wr_valid strobe per completed
//   register write (sub-address + one data byte; no auto-increment).
// Parameters:
//   DEV_ID : 8-bit write ID (bit 0 = 0); read ID is DEV_ID|1.
// Ports:
//   clk  : system clock, all bus inputs sampled on its rising edge
//   rst  : synchronous reset, active-high
//   bus  : sccb_target_if.slave (SIOC_in, SIOD_in, rd_data in;
//          SIOD_oe, busy, wr_valid, wr_addr, wr_data, rd_addr out)
// Build option:
//   SCCB_TARGET_READ_EN : when defined, the read ID is ACKed and the target
//   shifts rd_data out MSB first, then ignores the master NA.
module sccb_target #(
  parameter logic [7:0] DEV_ID = 8'h42
) (
  input  logic          clk,
  input  logic          rst,
  sccb_target_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID,
    S_ID_ACK,
    S_SUB,
    S_SUB_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE,
    S_READ,
    S_READ_NA
  } state_t;

  // Synchronisers and previous-cycle copies (idle bus = 1)
  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;

  state_t     r_state, w_state_next;
  logic [3:0] r_bitcnt, w_bitcnt_next;
  logic [7:0] r_shift, w_shift_next;
  logic [7:0] r_rd_addr, w_rd_addr_next;
  logic [7:0] r_wr_addr, w_wr_addr_next;
  logic [7:0] r_wr_data, w_wr_data_next;
  logic       r_wr_valid, w_wr_valid_next;
  logic       r_siod_oe, w_siod_oe_next;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic       w_byte_done, w_shifting;

`ifdef SCCB_TARGET_READ_EN
  logic [7:0] r_tx, w_tx_next;
  logic       r_rd_mode, w_rd_mode_next;
`else
  logic       w_unused_rd;
  assign w_unused_rd = ^bus.rd_data;
`endif

  // Conditions require SIOC high in both cycles so a simultaneous SIOC fall
  // and SIOD change is never mistaken for START/STOP.
  assign w_scl_rise  = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall  = ~r_scl_s2 & r_scl_d;
  assign w_start     = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
  assign w_stop      = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
  assign w_byte_done = w_scl_fall && (r_bitcnt == 4'd8);
  assign w_shifting  = (r_state == S_ID) || (r_state == S_SUB) || (r_state == S_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_valid <= 1'b0;
      r_siod_oe  <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
      r_tx       <= '0;
      r_rd_mode  <= 1'b0;
`endif
    end else begin
      r_scl_s1   <= bus.SIOC_in;
      r_scl_s2   <= r_scl_s1;
      r_scl_d    <= r_scl_s2;
      r_sda_s1   <= bus.SIOD_in;
      r_sda_s2   <= r_sda_s1;
      r_sda_d    <= r_sda_s2;
      r_state    <= w_state_next;
      r_bitcnt   <= w_bitcnt_next;
      r_shift    <= w_shift_next;
      r_rd_addr  <= w_rd_addr_next;
      r_wr_addr  <= w_wr_addr_next;
      r_wr_data  <= w_wr_data_next;
      r_wr_valid <= w_wr_valid_next;
      r_siod_oe  <= w_siod_oe_next;
`ifdef SCCB_TARGET_READ_EN
      r_tx       <= w_tx_next;
      r_rd_mode  <= w_rd_mode_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_bitcnt_next   = r_bitcnt;
    w_shift_next    = r_shift;
    w_rd_addr_next  = r_rd_addr;
    w_wr_addr_next  = r_wr_addr;
    w_wr_data_next  = r_wr_data;
    w_wr_valid_next = 1'b0;
`ifdef SCCB_TARGET_READ_EN
    w_tx_next       = r_tx;
    w_rd_mode_next  = r_rd_mode;
`endif

    if (w_stop) begin
      w_state_next = S_IDLE;
    end else if (w_start) begin
      w_state_next  = S_ID;
      w_bitcnt_next = '0;
`ifdef SCCB_TARGET_READ_EN
      w_rd_mode_next = 1'b0;
`endif
    end else begin
      if (w_shifting && w_scl_rise && (r_bitcnt != 4'd8)) begin
        w_shift_next  = {r_shift[6:0], r_sda_s2};
        w_bitcnt_next = r_bitcnt + 4'd1;
      end

      case (r_state)
        S_ID: begin
          if (w_byte_done) begin
            w_bitcnt_next = '0;
            if (r_shift == DEV_ID) begin
              w_state_next = S_ID_ACK;
`ifdef SCCB_TARGET_READ_EN
            end else if (r_shift == (DEV_ID | 8'h01)) begin
              w_state_next   = S_ID_ACK;
              w_rd_mode_next = 1'b1;
`endif
            end else begin
              w_state_next = S_IGNORE;
            end
          end
        end
        S_ID_ACK: begin
          if (w_scl_fall) begin
`ifdef SCCB_TARGET_READ_EN
            if (r_rd_mode) begin
              w_state_next  = S_READ;
              w_tx_next     = bus.rd_data;
              w_bitcnt_next = '0;
            end else begin
              w_state_next = S_SUB;
            end
`else
            w_state_next = S_SUB;
`endif
          end
        end
        S_SUB: begin
          if (w_byte_done) begin
            w_bitcnt_next  = '0;
            w_rd_addr_next = r_shift;
            w_state_next   = S_SUB_ACK;
          end
        end
        S_SUB_ACK: begin
          if (w_scl_fall) w_state_next = S_DATA;
        end
        S_DATA: begin
          if (w_byte_done) begin
            w_bitcnt_next = '0;
            w_state_next  = S_DATA_ACK;
          end
        end
        S_DATA_ACK: begin
          // r_shift is frozen outside the shifting states, so it still
          // holds the data byte here.
          if (w_scl_fall) begin
            w_wr_addr_next  = r_rd_addr;
            w_wr_data_next  = r_shift;
            w_wr_valid_next = 1'b1;
            w_state_next    = S_IGNORE;
          end
        end
`ifdef SCCB_TARGET_READ_EN
        // Bit 7 goes out on the ACK-ending fall; each later fall advances one
        // bit, and the fall that ends bit 0 releases the line for the NA.
        S_READ: begin
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd7) begin
              w_bitcnt_next = '0;
              w_state_next  = S_READ_NA;
            end else begin
              w_tx_next     = {r_tx[6:0], 1'b0};
              w_bitcnt_next = r_bitcnt + 4'd1;
            end
          end
        end
        S_READ_NA: begin
          if (w_scl_fall) w_state_next = S_IGNORE;
        end
`endif
        default: ;
      endcase
    end
  end

  // The pulldown follows the registered state, giving one extra clk after
  // the FSM reacts to an SIOC fall.
  always_comb begin
    w_siod_oe_next = (r_state == S_ID_ACK) || (r_state == S_SUB_ACK) ||
                     (r_state == S_DATA_ACK);
`ifdef SCCB_TARGET_READ_EN
    if ((r_state == S_READ) && !r_tx[7]) w_siod_oe_next = 1'b1;
`endif
  end

  assign bus.SIOD_oe  = r_siod_oe;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.rd_addr  = r_rd_addr;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed bench for sccb_target. 25 MHz clk, ~100 kHz SCCB
// master model driving an open-drain SIOD line (line = master & ~SIOD_oe).
module tb_sccb_target;
  localparam int Q = 62;  // quarter SCCB bit period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

  int oe_pulses = 0;
  int wv_count = 0;
  int wv_run = 0;
  int wv_max = 0;
  logic [7:0] wv_addr = 8'h00;
  logic [7:0] wv_data = 8'h00;
  logic prev_oe = 1'b0;

  int lat_oe, lat_rel, lat_wv, lat_busy;
  bit inject_rst = 1'b0;
  logic rst_oe, rst_busy;

  sccb_target_if bus_if ();

  assign bus_if.SIOC_in = m_scl;
  assign bus_if.SIOD_in = m_sda & ~bus_if.SIOD_oe;
  assign bus_if.rd_data = 8'hA5;

  sccb_target #(.DEV_ID(8'h42)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.SIOD_oe && !prev_oe) oe_pulses++;
    prev_oe = bus_if.SIOD_oe;
    if (bus_if.wr_valid) begin
      wv_count++;
      wv_run++;
      wv_addr = bus_if.wr_addr;
      wv_data = bus_if.wr_data;
      if (wv_run > wv_max) wv_max = wv_run;
    end else begin
      wv_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0;
    lat_busy = -1;
    for (int c = 1; c <= Q; c++) begin
      tick(1);
      if (lat_busy < 0 && bus_if.busy) lat_busy = c;
    end
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2 * Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1; tick(2 * Q);
      m_scl = 1'b0; tick(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1; tick(2 * Q);
      m_scl = 1'b0;
      if (i == 0) begin
        lat_oe = -1;
        for (int c = 1; c <= Q; c++) begin
          tick(1);
          if (c == 2) m_sda = 1'b1;
          if (lat_oe < 0 && bus_if.SIOD_oe) lat_oe = c;
        end
      end else begin
        tick(Q);
      end
    end
    if (inject_rst) begin
      rst = 1'b1;
      tick(1);
      rst_oe = bus_if.SIOD_oe;
      rst_busy = bus_if.busy;
      rst = 1'b0;
    end
    m_scl = 1'b1; tick(Q);
    ack = (bus_if.SIOD_in == 1'b0);
    tick(Q);
    m_scl = 1'b0;
    lat_rel = -1;
    lat_wv = -1;
    for (int c = 1; c <= Q; c++) begin
      tick(1);
      if (lat_rel < 0 && !bus_if.SIOD_oe) lat_rel = c;
      if (lat_wv < 0 && bus_if.wr_valid) lat_wv = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_cmp++; if (bus_if.SIOD_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", bus_if.SIOD_oe); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", bus_if.wr_valid); end
    n_cmp++; if (bus_if.wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 00", bus_if.wr_addr); end
    n_cmp++; if (bus_if.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", bus_if.wr_data); end
    n_cmp++; if (bus_if.rd_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 00", bus_if.rd_addr); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int p0, w0;
    p0 = oe_pulses; w0 = wv_count;
    bus_start();
    n_cmp++; if (lat_busy !== 3) begin n_fail++; $display("FAIL wr_busy_latency: got %0d want 3", lat_busy); end
    send_byte(8'h42, a0);
    n_cmp++; if (lat_oe !== 4) begin n_fail++; $display("FAIL wr_oe_set_latency: got %0d want 4", lat_oe); end
    n_cmp++; if (lat_rel !== 4) begin n_fail++; $display("FAIL wr_oe_clr_latency: got %0d want 4", lat_rel); end
    send_byte(8'h12, a1);
    n_cmp++; if (bus_if.rd_addr !== 8'h12) begin n_fail++; $display("FAIL wr_rd_addr: got %h want 12", bus_if.rd_addr); end
    send_byte(8'h80, a2);
    n_cmp++; if (lat_wv !== 3) begin n_fail++; $display("FAIL wr_valid_latency: got %0d want 3", lat_wv); end
    bus_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL wr_acks: got %b want 111", {a0, a1, a2}); end
    n_cmp++; if (oe_pulses - p0 !== 3) begin n_fail++; $display("FAIL wr_ack_pulses: got %0d want 3", oe_pulses - p0); end
    n_cmp++; if (wv_count - w0 !== 1) begin n_fail++; $display("FAIL wr_strobes: got %0d want 1", wv_count - w0); end
    n_cmp++; if (wv_max !== 1) begin n_fail++; $display("FAIL wr_strobe_width: got %0d want 1", wv_max); end
    n_cmp++; if ({wv_addr, wv_data} !== 16'h1280) begin n_fail++; $display("FAIL wr_strobe_payload: got %h want 1280", {wv_addr, wv_data}); end
    n_cmp++; if ({bus_if.wr_addr, bus_if.wr_data} !== 16'h1280) begin n_fail++; $display("FAIL wr_held_payload: got %h want 1280", {bus_if.wr_addr, bus_if.wr_data}); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop: got %b want 0", bus_if.busy); end
  endtask

  task automatic test_wrong_id();
    logic a0, a1, a2;
    int p0, w0;
    p0 = oe_pulses; w0 = wv_count;
    bus_start();
    send_byte(8'h60, a0);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    bus_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL nid_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (oe_pulses - p0 !== 0) begin n_fail++; $display("FAIL nid_oe_pulses: got %0d want 0", oe_pulses - p0); end
    n_cmp++; if (wv_count - w0 !== 0) begin n_fail++; $display("FAIL nid_strobes: got %0d want 0", wv_count - w0); end
    n_cmp++; if ({bus_if.wr_addr, bus_if.wr_data, bus_if.rd_addr} !== 24'h128012) begin n_fail++; $display("FAIL nid_outputs: got %h want 128012", {bus_if.wr_addr, bus_if.wr_data, bus_if.rd_addr}); end
  endtask

  task automatic test_two_phase_and_long();
    logic a0, a1, a2, a3;
    int w0;
    w0 = wv_count;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1);
    bus_stop();
    n_cmp++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL two_phase_acks: got %b want 11", {a0, a1}); end
    n_cmp++; if (bus_if.rd_addr !== 8'h0A) begin n_fail++; $display("FAIL two_phase_rd_addr: got %h want 0a", bus_if.rd_addr); end
    n_cmp++; if (wv_count - w0 !== 0) begin n_fail++; $display("FAIL two_phase_strobes: got %0d want 0", wv_count - w0); end
    n_cmp++; if ({bus_if.wr_addr, bus_if.wr_data} !== 16'h1280) begin n_fail++; $display("FAIL two_phase_wr_held: got %h want 1280", {bus_if.wr_addr, bus_if.wr_data}); end
    w0 = wv_count;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h11, a1);
    send_byte(8'h22, a2);
    send_byte(8'h33, a3);
    bus_stop();
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b1110) begin n_fail++; $display("FAIL long_acks: got %b want 1110", {a0, a1, a2, a3}); end
    n_cmp++; if (wv_count - w0 !== 1) begin n_fail++; $display("FAIL long_strobes: got %0d want 1", wv_count - w0); end
    n_cmp++; if ({bus_if.wr_addr, bus_if.wr_data} !== 16'h1122) begin n_fail++; $display("FAIL long_payload: got %h want 1122", {bus_if.wr_addr, bus_if.wr_data}); end
  endtask

  task automatic test_restart();
    logic a0, a1, a2, a3;
    int w0;
    w0 = wv_count;
    bus_start();
    send_byte(8'h42, a0);
    send_bits(8'h12, 4);
    bus_start();
    send_byte(8'h42, a1);
    send_byte(8'h3A, a2);
    send_byte(8'h04, a3);
    bus_stop();
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL restart_acks: got %b want 1111", {a0, a1, a2, a3}); end
    n_cmp++; if (wv_count - w0 !== 1) begin n_fail++; $display("FAIL restart_strobes: got %0d want 1", wv_count - w0); end
    n_cmp++; if ({bus_if.wr_addr, bus_if.wr_data} !== 16'h3A04) begin n_fail++; $display("FAIL restart_payload: got %h want 3a04", {bus_if.wr_addr, bus_if.wr_data}); end
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2;
    int w0;
    w0 = wv_count;
    bus_start();
    send_byte(8'h42, a0);
    inject_rst = 1'b1;
    send_byte(8'h12, a1);
    inject_rst = 1'b0;
    bus_stop();
    n_cmp++; if (rst_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe: got %b want 0", rst_oe); end
    n_cmp++; if (rst_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", rst_busy); end
    n_cmp++; if (wv_count - w0 !== 0) begin n_fail++; $display("FAIL rst_mid_strobes: got %0d want 0", wv_count - w0); end
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h55, a1);
    send_byte(8'h66, a2);
    bus_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rst_after_acks: got %b want 111", {a0, a1, a2}); end
    n_cmp++; if (wv_count - w0 !== 1) begin n_fail++; $display("FAIL rst_after_strobes: got %0d want 1", wv_count - w0); end
    n_cmp++; if ({bus_if.wr_addr, bus_if.wr_data} !== 16'h5566) begin n_fail++; $display("FAIL rst_after_payload: got %h want 5566", {bus_if.wr_addr, bus_if.wr_data}); end
  endtask

  task automatic test_read_id();
    logic a0, a1;
    int p0, w0;
`ifdef SCCB_TARGET_READ_EN
    logic [7:0] v;
    logic na_line;
`endif
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1);
    bus_stop();
    p0 = oe_pulses; w0 = wv_count;
    bus_start();
    send_byte(8'h43, a0);
`ifdef SCCB_TARGET_READ_EN
    for (int i = 7; i >= 0; i--) begin
      m_scl = 1'b1; tick(Q);
      v[i] = bus_if.SIOD_in;
      tick(Q);
      m_scl = 1'b0; tick(2 * Q);
    end
    m_scl = 1'b1; tick(Q);
    na_line = bus_if.SIOD_in;
    tick(Q);
    m_scl = 1'b0; tick(2 * Q);
    bus_stop();
    n_cmp++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL read_id_ack: got %b want 1", a0); end
    n_cmp++; if (v !== 8'hA5) begin n_fail++; $display("FAIL read_bits: got %h want a5", v); end
    n_cmp++; if (na_line !== 1'b1) begin n_fail++; $display("FAIL read_na_released: got %b want 1", na_line); end
`else
    send_byte(8'h00, a1);
    bus_stop();
    n_cmp++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL read_id_acks: got %b want 00", {a0, a1}); end
    n_cmp++; if (oe_pulses - p0 !== 0) begin n_fail++; $display("FAIL read_id_oe_pulses: got %0d want 0", oe_pulses - p0); end
`endif
    n_cmp++; if (wv_count - w0 !== 0) begin n_fail++; $display("FAIL read_id_strobes: got %0d want 0", wv_count - w0); end
    n_cmp++; if (bus_if.SIOD_oe !== 1'b0) begin n_fail++; $display("FAIL read_id_oe_end: got %b want 0", bus_if.SIOD_oe); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_id();
    test_two_phase_and_long();
    test_restart();
    test_reset_mid();
    test_read_id();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB write-target (camera-side responder) for the OV7670 driver path. It passively samples the SIOC/SIOD bus lines and recognises START and STOP conditions. It acknowledges 3-phase write transactions addressed to its device ID by pulling SIOD low, and presents each completed register write as a one-cycle strobe. The block is used as an in-FPGA camera register model and as the bus-functional counterpart when verifying the SCCB initiator.

## Interface
- `DEV_ID`, default 8'h42: 8-bit write ID. Bit 0 must be 0; the read ID is `DEV_ID|1`.
- `clk`  in  1  system clock; every bus input is sampled on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `SIOC_in`  in  1  bus clock line level, asynchronous.
- `SIOD_in`  in  1  bus data line level, asynchronous.
- `SIOD_oe`  out  1  inverting pulldown: 1 = drive SIOD low, 0 = release.
- `busy`  out  1  high from START detect until STOP detect.
- `wr_valid`  out  1  one-cycle register-write strobe.
- `wr_addr`  out  8  sub-address of the last write; held stable.
- `wr_data`  out  8  data of the last write; held stable.
- `rd_addr`  out  8  last received sub-address; held stable.
- `rd_data`  in  8  register value for `rd_addr`. Used only with `SCCB_TARGET_READ_EN`.

## Operation
- Input conditioning:
  - Each bus input passes through a 2-flop synchroniser.
  - Edges are detected on the synchronised values, compared against the previous cycle.
- Bus condition detection:
  - START: synchronised SIOD falls while synchronised SIOC is high.
  - STOP: synchronised SIOD rises while synchronised SIOC is high.
  - A data bit is sampled on each SIOC rising edge, MSB first.
- States: IDLE, ID, ID_ACK, SUB, SUB_ACK, DATA, DATA_ACK, IGNORE, and READ/READ_NA (macro only).
- START from any state:
  - Bit counter clears, `busy`=1, next state is ID.
  - A repeated START mid-transfer therefore restarts the transaction.
  - No `wr_valid` is issued for the aborted transaction.
- STOP from any state: next state is IDLE, `SIOD_oe`=0, `busy`=0.
- ID phase:
  - After 8 bits, if the byte equals `DEV_ID`, go to ID_ACK.
  - Otherwise go to IGNORE. No ACK is driven, and IGNORE is left only on START or STOP.
- ACK slots (ID_ACK, SUB_ACK, DATA_ACK):
  - `SIOD_oe` is set on the SIOC falling edge that ends bit 8.
  - It is cleared on the SIOC falling edge that ends the 9th clock.
- SUB_ACK: the sub-address byte is latched into `rd_addr` on entry.
- DATA_ACK exit, on the falling edge that ends the ACK:
  - `wr_addr` and `wr_data` are loaded.
  - `wr_valid`=1 for exactly one cycle.
  - Next state is IGNORE; further data bytes are neither ACKed nor written, and there is no auto-increment.
- A 2-phase write (STOP after SUB_ACK) updates only `rd_addr`; no strobe is issued.
- Bit counter is 4 bits and counts 0..8. It is reset on START and at each byte boundary.

## Timing
- Reset values:
  - `SIOD_oe`=0, `busy`=0, `wr_valid`=0.
  - `wr_addr`=0, `wr_data`=0, `rd_addr`=0.
  - State = IDLE; synchroniser flops = 1 (idle bus).
- Latency, pin edge → internal edge detect: 3 clk (2 sync + 1 edge register).
- `SIOD_oe` changes on the clk after internal detection, i.e. 4 clk after the SIOC pin falling edge.
  - This must be well below ¼ SCCB period, e.g. 62 clk at 25 MHz/100 kHz.
- `busy` rises 3 clk after the SIOD pin falling edge of START.
- `wr_valid` pulses 3 clk after the SIOC pin falling edge that ends the data ACK.
- `rst` mid-transfer: on the next clk, `SIOD_oe`=0, state = IDLE, and any pending strobe is dropped.
- Simultaneous START/STOP and a bit edge cannot occur: SIOC is high for both conditions. A STOP takes priority over any pending ACK.

## Configuration
- `SCCB_TARGET_READ_EN` defined:
  - ID byte `DEV_ID|1` is ACKed, then the block enters READ.
  - `rd_data` is captured at the ACK-ending falling edge.
  - On each of the next 8 SIOC falling edges, `SIOD_oe` = ~bit, MSB first.
  - In the 9th slot (READ_NA) `SIOD_oe`=0 and the block ignores the master NA, then goes to IGNORE.
- `SCCB_TARGET_READ_EN` undefined: `DEV_ID|1` is treated as an ID mismatch (no ACK, IGNORE), and the `rd_data` port is unused.

## Test plan
- Setup: 25 MHz clk, 100 kHz bus model.
- Write 0x42, 0x12, 0x80, STOP → three ACK low pulses on SIOD; one `wr_valid` with `wr_addr`=0x12, `wr_data`=0x80; `busy` falls after STOP.
- Write with ID 0x60 → `SIOD_oe` stays 0 through the transaction; no `wr_valid`; outputs unchanged.
- 0x42, 0x0A, STOP → `rd_addr`=0x0A, no `wr_valid`; then 4-byte write 0x42, 0x11, 0x22, 0x33 → one strobe (0x11/0x22), fourth byte not ACKed.
- START, 0x42, 4 bits of 0x12, repeated START, 0x42, 0x3A, 0x04, STOP → single strobe (0x3A/0x04).
- `rst` asserted while `SIOD_oe`=1 in SUB_ACK → `SIOD_oe`=0 and `busy`=0 on the next clk; the subsequent full write succeeds.
- With macro defined: 0x42, 0x0A, STOP; then 0x43 with `rd_data`=0xA5 → SIOD shows 1,0,1,0,0,1,0,1, then released for NA. Without macro, 0x43 → no ACK.
